// File: rtl/itch_pkg.sv
// ============================================================================
// Module : itch_pkg
// Brief  : Shared types and constants for the ITCH event-path blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package itch_pkg;

    localparam logic [7:0] ITCH_MSG_REPLACE = 8'h55;

    typedef struct packed {
        logic [63:0] old_ref;
        logic [63:0] new_ref;
        logic [31:0] shares;
        logic [31:0] price;
    } replace_evt_t;

    localparam int REPLACE_EVT_W = $bits(replace_evt_t);

    function automatic logic is_replace_msg(input logic [7:0] msg_type);
        return msg_type == ITCH_MSG_REPLACE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/itch_sync_fifo.sv
// ============================================================================
// Module : itch_sync_fifo
// Brief  : Generic first-word-fall-through FIFO with separate level counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module itch_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               LVL_W    = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (level_q == '0);
    assign w_full  = (level_q == FULL_LVL);

    // A push while full is only legal when the head leaves in the same cycle.
    assign w_pop  = pop_i & ~w_empty;
    assign w_push = push_i & (~w_full | w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately left unreset; the read mask hides stale data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = w_empty ? '0 : mem_q[rd_ptr_q];
    assign empty_o = w_empty;
    assign full_o  = w_full;
    assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/replace_event_fifo.sv
// ============================================================================
// Module : replace_event_fifo
// Brief  : Buffers decoded Replace Order events for the order-book stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module replace_event_fifo
    import itch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   replace_internal_valid,
    input  logic                   replace_packet_invalid,
    input  logic [63:0]            replace_old_order_ref,
    input  logic [63:0]            replace_new_order_ref,
    input  logic [31:0]            replace_shares,
    input  logic [31:0]            replace_price,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [63:0]            evt_old_order_ref,
    output logic [63:0]            evt_new_order_ref,
    output logic [31:0]            evt_shares,
    output logic [31:0]            evt_price,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   fifo_full,
    output logic [CNT_W-1:0]       invalid_cnt,
    output logic [CNT_W-1:0]       overflow_cnt
);

    replace_evt_t w_wr_evt;
    replace_evt_t w_rd_evt;

    logic w_push_req;
    logic w_push_acc;
    logic w_pop;
    logic w_drop;
    logic w_empty;
    logic w_full;
    logic w_inv_rise;

    logic             inv_prev_q;
    logic [CNT_W-1:0] invalid_cnt_q,  invalid_cnt_d;
    logic [CNT_W-1:0] overflow_cnt_q, overflow_cnt_d;

    assign w_wr_evt.old_ref = replace_old_order_ref;
    assign w_wr_evt.new_ref = replace_new_order_ref;
    assign w_wr_evt.shares  = replace_shares;
    assign w_wr_evt.price   = replace_price;

    // A malformed flag in the same cycle vetoes the event outright.
    assign w_push_req = replace_internal_valid & ~replace_packet_invalid;
    assign w_pop      = ~w_empty & evt_ready;
    assign w_push_acc = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_inv_rise = replace_packet_invalid & ~inv_prev_q;

    itch_sync_fifo #(
        .WIDTH (REPLACE_EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push_acc),
        .wdata_i (w_wr_evt),
        .pop_i   (w_pop),
        .rdata_o (w_rd_evt),
        .empty_o (w_empty),
        .full_o  (w_full),
        .level_o (fifo_level)
    );

    always_comb begin
        invalid_cnt_d  = invalid_cnt_q;
        overflow_cnt_d = overflow_cnt_q;
        if (w_inv_rise && (invalid_cnt_q != '1)) begin
            invalid_cnt_d = invalid_cnt_q + CNT_W'(1);
        end
        if (w_drop && (overflow_cnt_q != '1)) begin
            overflow_cnt_d = overflow_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_prev_q     <= 1'b0;
            invalid_cnt_q  <= '0;
            overflow_cnt_q <= '0;
        end else begin
            inv_prev_q     <= replace_packet_invalid;
            invalid_cnt_q  <= invalid_cnt_d;
            overflow_cnt_q <= overflow_cnt_d;
        end
    end

    assign evt_valid         = ~w_empty;
    assign evt_old_order_ref = w_rd_evt.old_ref;
    assign evt_new_order_ref = w_rd_evt.new_ref;
    assign evt_shares        = w_rd_evt.shares;
    assign evt_price         = w_rd_evt.price;
    assign fifo_full         = w_full;
    assign invalid_cnt       = invalid_cnt_q;
    assign overflow_cnt      = overflow_cnt_q;

endmodule

`default_nettype wire
